// File: rtl/delivery_locker_pkg.sv
// Shared types and constants for the delivery locker bank controller.
//   state_e             : controller state (idle / door open / lockout)
//   DEFAULT_COURIER_PIN : factory courier authorisation PIN
package delivery_locker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  localparam logic [3:0] DEFAULT_COURIER_PIN = 4'b1010;

endpackage

// File: rtl/delivery_locker_ctrl_prio_enc.sv
// locker_prio_enc: lowest-index-first priority encoder.
//   req   in  N    request vector
//   idx   out IW   index of the lowest set bit of req (0 when none set)
//   valid out 1    at least one bit of req is set
module locker_prio_enc #(
  parameter int  N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/delivery_locker_ctrl.sv
// delivery_locker_ctrl: locker bank controller between the keypad/sensor front
// end and the door solenoids. A courier deposits a parcel into the lowest free
// locker tagged with a recipient PIN; the recipient later retrieves it by PIN.
// Repeated bad retrieval PINs put the bank into a timed lockout.
// Ports:
//   clk, reset, reset_lockers   clock, two synchronous active-high clears
//   dep_req, package_present,   deposit request with parcel sensor,
//   courier_pin, user_pin       courier PIN and recipient PIN to store
//   ret_req, user_pin_retrieval retrieval request and presented PIN
//   auth_success_led            1-cycle pulse, deposit accepted
//   retrieval_auth_led          1-cycle pulse, retrieval PIN matched
//   reject                      1-cycle pulse, request refused
//   assigned_locker_display     index of the last opened locker
//   locker_doors                one-hot door drive
//   occupied, full              occupancy map and all-occupied flag
//   busy, lockout               state != IDLE, state == LOCKOUT
// All outputs are registered.
module delivery_locker_ctrl
  import delivery_locker_pkg::*;
#(
  parameter int               NUM_LOCKERS      = 8,
  parameter int               PIN_W            = 4,
  parameter logic [PIN_W-1:0] COURIER_PIN      = PIN_W'(DEFAULT_COURIER_PIN),
  parameter int               DOOR_OPEN_CYCLES = 16,
  parameter int               MAX_FAILS        = 3,
  parameter int               LOCKOUT_CYCLES   = 64,
  localparam int              IDX_W            = $clog2(NUM_LOCKERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reset_lockers,
  input  logic                   dep_req,
  input  logic                   package_present,
  input  logic [PIN_W-1:0]       courier_pin,
  input  logic [PIN_W-1:0]       user_pin,
  input  logic                   ret_req,
  input  logic [PIN_W-1:0]       user_pin_retrieval,
  output logic                   auth_success_led,
  output logic                   retrieval_auth_led,
  output logic                   reject,
  output logic [IDX_W-1:0]       assigned_locker_display,
  output logic [NUM_LOCKERS-1:0] locker_doors,
  output logic [NUM_LOCKERS-1:0] occupied,
  output logic                   full,
  output logic                   busy,
  output logic                   lockout
);

  // One timer serves both the door and the lockout phases.
  localparam int TMR_MAX = (DOOR_OPEN_CYCLES > LOCKOUT_CYCLES) ? DOOR_OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [FAIL_W-1:0]      fail_cnt_q, fail_cnt_d;
  logic [NUM_LOCKERS-1:0] occupied_q, occupied_d;
  logic [PIN_W-1:0]       pins_q [NUM_LOCKERS];
  logic [PIN_W-1:0]       pins_d [NUM_LOCKERS];
  logic [NUM_LOCKERS-1:0] doors_q, doors_d;
  logic [IDX_W-1:0]       display_q, display_d;
  logic                   auth_q, auth_d;
  logic                   ret_led_q, ret_led_d;
  logic                   reject_q, reject_d;
  logic                   full_q, full_d;
  logic                   busy_q, busy_d;
  logic                   lockout_q, lockout_d;

  logic [NUM_LOCKERS-1:0] match_vec;
  logic [IDX_W-1:0]       match_idx, free_idx;
  logic                   match_valid, free_valid;
  logic [FAIL_W-1:0]      fail_inc;
  logic                   dep_ok;

  // Only occupied lockers take part in the PIN comparison.
  for (genvar gi = 0; gi < NUM_LOCKERS; gi++) begin : g_match
    assign match_vec[gi] = occupied_q[gi] && (pins_q[gi] == user_pin_retrieval);
  end

  locker_prio_enc #(.N(NUM_LOCKERS)) u_match_enc (
    .req   (match_vec),
    .idx   (match_idx),
    .valid (match_valid)
  );

  locker_prio_enc #(.N(NUM_LOCKERS)) u_free_enc (
    .req   (~occupied_q),
    .idx   (free_idx),
    .valid (free_valid)
  );

  assign fail_inc = fail_cnt_q + FAIL_W'(1);
  // A free slot exists exactly when the bank is not full.
  assign dep_ok   = (courier_pin == COURIER_PIN) && package_present && free_valid;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    fail_cnt_d = fail_cnt_q;
    occupied_d = occupied_q;
    pins_d     = pins_q;
    doors_d    = doors_q;
    display_d  = display_q;
    auth_d     = 1'b0;
    ret_led_d  = 1'b0;
    reject_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ret_req) begin
          if (match_valid) begin
            ret_led_d             = 1'b1;
            occupied_d[match_idx] = 1'b0;
            fail_cnt_d            = '0;
            doors_d               = '0;
            doors_d[match_idx]    = 1'b1;
            display_d             = match_idx;
            timer_d               = '0;
            state_d               = ST_OPEN;
          end else begin
            reject_d   = 1'b1;
            fail_cnt_d = fail_inc;
            if (fail_inc == FAIL_W'(MAX_FAILS)) begin
              timer_d = '0;
              state_d = ST_LOCKOUT;
            end
          end
        end else if (dep_req) begin
          if (dep_ok) begin
            auth_d               = 1'b1;
            pins_d[free_idx]     = user_pin;
            occupied_d[free_idx] = 1'b1;
            doors_d              = '0;
            doors_d[free_idx]    = 1'b1;
            display_d            = free_idx;
            timer_d              = '0;
            state_d              = ST_OPEN;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      ST_OPEN: begin
        // Timer was cleared on entry, so the door stays up DOOR_OPEN_CYCLES cycles.
        if (timer_q == TMR_W'(DOOR_OPEN_CYCLES - 1)) begin
          doors_d = '0;
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_LOCKOUT: begin
        reject_d = ret_req || dep_req;
        if (timer_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
          fail_cnt_d = '0;
          timer_d    = '0;
          state_d    = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        doors_d = '0;
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    full_d    = &occupied_d;
    busy_d    = (state_d != ST_IDLE);
    lockout_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (reset || reset_lockers) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      fail_cnt_q <= '0;
      occupied_q <= '0;
      for (int i = 0; i < NUM_LOCKERS; i++) pins_q[i] <= '0;
      doors_q    <= '0;
      display_q  <= '0;
      auth_q     <= 1'b0;
      ret_led_q  <= 1'b0;
      reject_q   <= 1'b0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      fail_cnt_q <= fail_cnt_d;
      occupied_q <= occupied_d;
      pins_q     <= pins_d;
      doors_q    <= doors_d;
      display_q  <= display_d;
      auth_q     <= auth_d;
      ret_led_q  <= ret_led_d;
      reject_q   <= reject_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      lockout_q  <= lockout_d;
    end
  end

  assign auth_success_led        = auth_q;
  assign retrieval_auth_led      = ret_led_q;
  assign reject                  = reject_q;
  assign assigned_locker_display = display_q;
  assign locker_doors            = doors_q;
  assign occupied                = occupied_q;
  assign full                    = full_q;
  assign busy                    = busy_q;
  assign lockout                 = lockout_q;

endmodule
